mem_req_responder: RTL and testbench

Responder end of the memory request interface used by the CPU memory stage, the accelerator and the DMA engine. It accepts level-held requests from three requesters, arbitrates round-robin, and performs one access at a time on a single-port synchronous data SRAM. It returns read data with a one-cycle `valid` pulse to the granted requester. It sits between the CPU memory stage, the accelerator and DMA request ports on one side and the backing data memory on the other.

---
 rtl/mem_resp_pkg.sv | 27 ++
 rtl/sram_sp.sv | 36 +++
 rtl/mem_req_responder.sv | 166 ++++++++++++++++
 tb/tb_mem_req_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_resp_pkg
//  Description : Shared types and constants for the memory request responder
//                (FSM state encoding, requester port indices).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mresp_state_t;

  localparam logic [1:0] PORT_CPU  = 2'd0;
  localparam logic [1:0] PORT_ACL  = 2'd1;
  localparam logic [1:0] PORT_DMA  = 2'd2;
  localparam int         NUM_PORTS = 3;

  // Ascending round-robin step over the three port indices (wraps DMA -> CPU)
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == PORT_DMA) ? PORT_CPU : p + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_sp.sv
`default_nettype none
// ============================================================================
//  Module      : sram_sp
//  Description : Single-port synchronous RAM, registered read port.
//                Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_sp #(
  parameter int N          = 32,
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [N-1:0]          wdata_i,
  output logic [N-1:0]          rdata_o
);

  logic [N-1:0] mem_q [1<<DEPTH_LOG2];
  logic [N-1:0] rdata_q;

  // Enabled access: optional write, and the (pre-write) word captured for read
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[idx_i] <= wdata_i;
      end
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_req_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_responder
//  Description : Round-robin responder for CPU / ACL / DMA requesters onto a
//                single-port synchronous SRAM. One access per 3 cycles:
//                IDLE (grant+latch) -> ACCESS (SRAM op) -> RESP (valid pulse).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_req_responder
  import mem_resp_pkg::*;
#(
  parameter int N          = 32,
  parameter int DEPTH_LOG2 = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_en_i,
  input  logic         acl_en_i,
  input  logic         dma_en_i,
  input  logic         cpu_wr_en_i,
  input  logic         acl_wr_en_i,
  input  logic         dma_wr_en_i,
  input  logic [N-1:0] cpu_addr_i,
  input  logic [N-1:0] acl_addr_i,
  input  logic [N-1:0] dma_addr_i,
  input  logic [N-1:0] cpu_data_i,
  input  logic [N-1:0] acl_data_i,
  input  logic [N-1:0] dma_data_i,
  output logic [N-1:0] cpu_out_o,
  output logic [N-1:0] acl_out_o,
  output logic [N-1:0] dma_out_o,
  output logic         cpu_valid_o,
  output logic         acl_valid_o,
  output logic         dma_valid_o,
  output logic         busy_o
);

  mresp_state_t state_q, state_d;

  logic [1:0]            ptr_q;
  logic [1:0]            port_q;
  logic                  wr_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [N-1:0]          wdata_q;
  logic [NUM_PORTS-1:0]  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic [N-1:0]          out_q [NUM_PORTS];

  logic [NUM_PORTS-1:0]  req_vec, wr_vec;
  logic [N-1:0]          addr_arr [NUM_PORTS];
  logic [N-1:0]          data_arr [NUM_PORTS];
  logic                  gnt_valid;
  logic [1:0]            gnt_idx, arb_cand;
  logic                  sram_en, sram_we;
  logic [N-1:0]          sram_rdata, resp_data;

  assign req_vec     = {dma_en_i, acl_en_i, cpu_en_i};
  assign wr_vec      = {dma_wr_en_i, acl_wr_en_i, cpu_wr_en_i};
  assign addr_arr[0] = cpu_addr_i;
  assign addr_arr[1] = acl_addr_i;
  assign addr_arr[2] = dma_addr_i;
  assign data_arr[0] = cpu_data_i;
  assign data_arr[1] = acl_data_i;
  assign data_arr[2] = dma_data_i;

  // Byte-offset and above-depth address bits are ignored, so addresses alias
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr_i[N-1:DEPTH_LOG2+2], cpu_addr_i[1:0],
                              acl_addr_i[N-1:DEPTH_LOG2+2], acl_addr_i[1:0],
                              dma_addr_i[N-1:DEPTH_LOG2+2], dma_addr_i[1:0]};

  // Round-robin search: first requesting port at or after the pointer
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr_q;
    arb_cand  = ptr_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!gnt_valid && req_vec[arb_cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = arb_cand;
      end
      arb_cand = next_port(arb_cand);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = gnt_valid ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: SRAM strobes gated by state so a reset drops an uncommitted write
  always_comb begin
    sram_en = (state_q == ACCESS);
    sram_we = (state_q == ACCESS) && wr_q;
    valid_d = '0;
    if (state_q == ACCESS) begin
      valid_d[port_q] = 1'b1;
    end
    busy_d  = (state_d != IDLE);
  end

  // Request latch, pointer update, registered flags and held response data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= PORT_CPU;
      port_q  <= PORT_CPU;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) out_q[p] <= '0;
    end else begin
      valid_q <= valid_d;
      busy_q  <= busy_d;
      if (state_q == IDLE && gnt_valid) begin
        ptr_q   <= next_port(gnt_idx);
        port_q  <= gnt_idx;
        wr_q    <= wr_vec[gnt_idx];
        idx_q   <= addr_arr[gnt_idx][DEPTH_LOG2+1:2];
        wdata_q <= data_arr[gnt_idx];
      end
      if (state_q == RESP) begin
        out_q[port_q] <= resp_data;
      end
    end
  end

  sram_sp #(
    .N          (N),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_sram (
    .clk     (clk),
    .en_i    (sram_en),
    .we_i    (sram_we),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (sram_rdata)
  );

  // Writes echo their data; reads return the registered SRAM word
  assign resp_data = wr_q ? wdata_q : sram_rdata;

  // During RESP the granted port sees the fresh result; otherwise held values
  assign cpu_out_o   = valid_q[PORT_CPU] ? resp_data : out_q[PORT_CPU];
  assign acl_out_o   = valid_q[PORT_ACL] ? resp_data : out_q[PORT_ACL];
  assign dma_out_o   = valid_q[PORT_DMA] ? resp_data : out_q[PORT_DMA];
  assign cpu_valid_o = valid_q[PORT_CPU];
  assign acl_valid_o = valid_q[PORT_ACL];
  assign dma_valid_o = valid_q[PORT_DMA];
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_req_responder
//  Description : Directed self-checking bench for mem_req_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  en;
  logic [2:0]  wr;
  logic [31:0] addr_a [3];
  logic [31:0] data_a [3];
  logic [31:0] cpu_out, acl_out, dma_out;
  logic        cpu_valid, acl_valid, dma_valid, busy;
  logic [2:0]  valid;

  int n_chk  = 0;
  int n_pass = 0;
  int vcyc [3];
  logic busy_c1;

  assign valid = {dma_valid, acl_valid, cpu_valid};

  always #5 clk = ~clk;

  mem_req_responder #(.N(32), .DEPTH_LOG2(14)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_en_i    (en[0]),
    .acl_en_i    (en[1]),
    .dma_en_i    (en[2]),
    .cpu_wr_en_i (wr[0]),
    .acl_wr_en_i (wr[1]),
    .dma_wr_en_i (wr[2]),
    .cpu_addr_i  (addr_a[0]),
    .acl_addr_i  (addr_a[1]),
    .dma_addr_i  (addr_a[2]),
    .cpu_data_i  (data_a[0]),
    .acl_data_i  (data_a[1]),
    .dma_data_i  (data_a[2]),
    .cpu_out_o   (cpu_out),
    .acl_out_o   (acl_out),
    .dma_out_o   (dma_out),
    .cpu_valid_o (cpu_valid),
    .acl_valid_o (acl_valid),
    .dma_valid_o (dma_valid),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else             n_pass++;
  endtask

  task automatic set_port(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    wr[p]     = w;
    addr_a[p] = a;
    data_a[p] = d;
  endtask

  task automatic wait_idle();
    for (int w = 0; w < 5 && busy; w++) begin
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Raise the requested enables together; each drops on its own valid.
  // vcyc[p] = cycle (1-based edges after raising en) at which valid was seen.
  task automatic run_multi(input logic [2:0] req, input int budget);
    logic [2:0] pend;
    wait_idle();
    pend = req;
    for (int p = 0; p < 3; p++) vcyc[p] = -1;
    en = req;
    for (int c = 1; c <= budget && pend != 3'b000; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 1) busy_c1 = busy;
      for (int p = 0; p < 3; p++) begin
        if (valid[p] && pend[p]) begin
          vcyc[p] = c;
          pend[p] = 1'b0;
          en[p]   = 1'b0;
        end
      end
    end
    if (pend != 3'b000) chk("timeout", {29'd0, pend}, 32'd0);
    en = '0;
  endtask

  initial begin
    int bad_busy, bad_valid, stray;
    logic [2:0] exp_v;
    rst_n = 1'b0;
    en    = '0;
    wr    = '0;
    for (int p = 0; p < 3; p++) begin
      addr_a[p] = '0;
      data_a[p] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_valid", {29'd0, valid}, 32'd0);
    chk("rst_cpu_out", cpu_out, 32'd0);
    chk("rst_acl_out", acl_out, 32'd0);
    chk("rst_dma_out", dma_out, 32'd0);

    // CPU write then read-back
    set_port(0, 1'b1, 32'h10, 32'hDEADBEEF);
    run_multi(3'b001, 20);
    chk("wr_latency", vcyc[0], 32'd2);
    chk("wr_busy_c1", {31'd0, busy_c1}, 32'd1);
    chk("wr_echo", cpu_out, 32'hDEADBEEF);
    set_port(0, 1'b0, 32'h10, 32'h0);
    run_multi(3'b001, 20);
    chk("rd_latency", vcyc[0], 32'd2);
    chk("rd_data", cpu_out, 32'hDEADBEEF);

    // Preload three words, reset, then three simultaneous reads
    set_port(0, 1'b1, 32'h40, 32'h11111111); run_multi(3'b001, 20);
    set_port(0, 1'b1, 32'h44, 32'h22222222); run_multi(3'b001, 20);
    set_port(0, 1'b1, 32'h48, 32'h33333333); run_multi(3'b001, 20);
    do_reset();
    set_port(0, 1'b0, 32'h40, 32'h0);
    set_port(1, 1'b0, 32'h44, 32'h0);
    set_port(2, 1'b0, 32'h48, 32'h0);
    run_multi(3'b111, 30);
    chk("rr3_cpu_cyc", vcyc[0], 32'd2);
    chk("rr3_acl_cyc", vcyc[1], 32'd5);
    chk("rr3_dma_cyc", vcyc[2], 32'd8);
    chk("rr3_cpu_out", cpu_out, 32'h11111111);
    chk("rr3_acl_out", acl_out, 32'h22222222);
    chk("rr3_dma_out", dma_out, 32'h33333333);

    // CPU and DMA requesting continuously: grants alternate
    wait_idle();
    stray = 0;
    en = 3'b101;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 2 || c == 5 || c == 8 || c == 11) begin
        exp_v = (c == 2 || c == 8) ? 3'b001 : 3'b100;
        chk($sformatf("alt_c%0d", c), {29'd0, valid}, {29'd0, exp_v});
      end else if (valid != 3'b000) begin
        stray++;
      end
    end
    en = '0;
    chk("alt_stray_valid", stray, 32'd0);
    chk("alt_cpu_out", cpu_out, 32'h11111111);
    chk("alt_dma_out", dma_out, 32'h33333333);

    // Address aliasing: byte offset and wrap above the depth
    set_port(2, 1'b1, 32'h4, 32'h12345678);
    run_multi(3'b100, 20);
    chk("alias_dma_echo", dma_out, 32'h12345678);
    set_port(1, 1'b0, 32'h7, 32'h0);
    run_multi(3'b010, 20);
    chk("alias_byteoff", acl_out, 32'h12345678);
    set_port(1, 1'b0, (32'd1 << 16) + 32'h4, 32'h0);
    run_multi(3'b010, 20);
    chk("alias_wrap", acl_out, 32'h12345678);

    // Reset during ACCESS drops the write
    set_port(0, 1'b1, 32'h20, 32'hAAAA5555);
    run_multi(3'b001, 20);
    wait_idle();
    set_port(1, 1'b1, 32'h20, 32'h0);
    en = 3'b010;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {29'd0, valid}, 32'd0);
    chk("mid_rst_cpu_out", cpu_out, 32'd0);
    chk("mid_rst_acl_out", acl_out, 32'd0);
    chk("mid_rst_dma_out", dma_out, 32'd0);
    en = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    set_port(0, 1'b0, 32'h20, 32'h0);
    set_port(2, 1'b0, 32'h48, 32'h0);
    run_multi(3'b101, 20);
    chk("post_rst_cpu_first", vcyc[0], 32'd2);
    chk("post_rst_dma_next",  vcyc[2], 32'd5);
    chk("post_rst_data", cpu_out, 32'hAAAA5555);
    chk("post_rst_dma_out", dma_out, 32'h33333333);

    // Idle: no activity for 10 cycles
    wait_idle();
    bad_busy  = 0;
    bad_valid = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      if (busy) bad_busy++;
      if (valid != 3'b000) bad_valid++;
    end
    chk("idle_busy", bad_busy, 32'd0);
    chk("idle_valid", bad_valid, 32'd0);
    chk("idle_cpu_out", cpu_out, 32'hAAAA5555);
    chk("idle_acl_out", acl_out, 32'd0);
    chk("idle_dma_out", dma_out, 32'h33333333);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
